lsu_ram_ctrl: RTL and testbench
===============================

// Module: lsu_ram_ctrl
// PURPOSE
// Load/store sequencer between the CPU execute stage and the 32x32 word data RAM.
// Takes byte-addressed byte/half/word requests, checks alignment and range, and
// drives the RAM's word port (combinational read, posedge write).
// Sub-word loads are extended; sub-word stores are done as a one-cycle read-merge-write.
// Returns one response per request over a valid/ready handshake.
// PARAMETERS
// DEPTH   32  RAM depth in 32-bit words (power of 2); legal byte range 0..4*DEPTH-1
// AW      5   log2(DEPTH); RAM word-index width actually used
// PORTS
// clk        in   1   clock, posedge
// rst_n      in   1   asynchronous, active-low reset
// req_valid  in   1   request present
// req_ready  out  1   unit can accept a request (high only in IDLE)
// req_we     in   1   1=store, 0=load
// req_size   in   2   00 byte, 01 half, 10 word, 11 reserved
// req_signed in   1   loads only: 1=sign-extend, 0=zero-extend
// req_addr   in   32  byte address
// req_wdata  in   32  store data, right-justified
// rsp_valid  out  1   response present
// rsp_ready  in   1   consumer takes response
// rsp_rdata  out  32  load result; 0 for stores and errors
// rsp_err    out  1   misaligned, out-of-range or reserved size
// ram_we     out  1   RAM write enable
// ram_addr   out  32  RAM word index {zeros, addr[AW+1:2]}
// ram_datain out  32  RAM write data
// ram_dataout in  32  RAM read data (combinational from ram_addr)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0,
//   rsp_err=0, ram_we=0, ram_addr=0, ram_datain=0. ram_we drops with rst_n, not at clk.
// - FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: req_ready=1; req_valid&req_ready at posedge latches we/size/signed/addr/wdata.
//   ACCESS (exactly 1 cycle): ram_addr = latched word index.
//     error check: size=11; half with addr[0]!=0; word with addr[1:0]!=0;
//     addr[31:AW+2]!=0. On error: ram_we=0, rsp_err<=1, rsp_rdata<=0.
//     load: lane = addr[1:0] (little-endian; byte k = bits 8k+7:8k), extend per
//       req_signed, rsp_rdata<=result; ram_we=0.
//     word store: ram_we=1, ram_datain=wdata.
//     byte/half store: ram_datain = ram_dataout with addressed lane(s) replaced
//       by wdata[7:0]/wdata[15:0]; ram_we=1. Write commits at end of ACCESS.
//   RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_ready=1 at posedge,
//     then IDLE. No new request accepted while in ACCESS or RESP.
// - Latency: accept at edge N, RAM access in cycle N+1, rsp_valid from edge N+2.
//   Throughput: one request per 3 cycles with rsp_ready tied high.
// - ram_we is asserted only in ACCESS; exactly one RAM write per legal store;
//   never for loads or errored requests.
// - Reset in ACCESS aborts: ram_we deasserts immediately, no write at next edge,
//   no response produced. Reset in RESP discards the pending response.
// - req_* ignored outside the IDLE handshake; changes there have no effect.
// - Word index wraps nowhere: out-of-range is an error, never aliased.
// STRUCTURE
// - lsu_pkg: SIZE_B/SIZE_H/SIZE_W/SIZE_RSV encodings, state enum
//   (ST_IDLE, ST_ACCESS, ST_RESP), function lane_mask(size, addr[1:0]).
// - Sub-module lsu_lane_align (combinational): extract+extend for loads,
//   merge for stores; lsu_ram_ctrl holds the FSM and request/response registers.
// TESTING
// 1 Preload word 20 = 0x000000A3; load byte signed @0x50 -> rsp_rdata=0xFFFFFFA3,
//   err=0, rsp_valid 2 cycles after accept; load half unsigned @0x50 -> 0x000000A3.
// 2 Store byte 0x5A @0x51 to word 20=0x000000A3 -> one ram_we pulse, word 20 =
//   0x00005AA3; store half 0xBEEF @0x52 -> 0xBEEF5AA3.
// 3 Load half @0x51, store word @0x52, size=11 -> rsp_err=1, rdata=0, no ram_we.
// 4 Load word @0x80 (DEPTH=32) -> rsp_err=1; load word @0x7C -> word 31 contents.
// 5 Hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata stable, req_ready=0;
//   back-to-back requests with rsp_ready=1 -> accepted every 3rd cycle.
// 6 Drop rst_n in ACCESS of store 0x11223344 @0x00 -> ram_we falls at once,
//   word 0 unchanged, no rsp_valid after release; all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, FSM states and
// the byte-lane mask helper used by the store merge path.
package lsu_pkg;

   localparam logic [1:0] SIZE_B   = 2'b00;
   localparam logic [1:0] SIZE_H   = 2'b01;
   localparam logic [1:0] SIZE_W   = 2'b10;
   localparam logic [1:0] SIZE_RSV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   // Little-endian byte lanes touched by an access of the given size at offset off.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      case (size)
         SIZE_B:  m = 4'b0001 << off;
         SIZE_H:  m = 4'b0011 << off;
         SIZE_W:  m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends sub-word load data, and
// merges sub-word store data into the word currently held in the RAM.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rword_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [31:0] shifted;
   logic [31:0] wrep;
   logic [3:0]  mask;

   always_comb begin
      shifted = rword_i >> {off_i, 3'b000};
      load_o  = 32'd0;
      case (size_i)
         SIZE_B:  load_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
         SIZE_H:  load_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
         SIZE_W:  load_o = rword_i;
         default: load_o = 32'd0;
      endcase
   end

   // Replicating the store data puts it on every lane, so the mask alone selects.
   always_comb begin
      mask    = lane_mask(size_i, off_i);
      merge_o = rword_i;
      case (size_i)
         SIZE_B:  wrep = {4{wdata_i[7:0]}};
         SIZE_H:  wrep = {2{wdata_i[15:0]}};
         default: wrep = wdata_i;
      endcase
      for (int k = 0; k < 4; k++) begin
         if (mask[k]) merge_o[8*k +: 8] = wrep[8*k +: 8];
      end
   end

endmodule

// File: rtl/lsu_ram_ctrl.sv
// Load/store sequencer between the execute stage and the word-wide data RAM.
// Valid/ready on both sides: a transfer happens on a posedge where valid and ready are both high.
module lsu_ram_ctrl
   import lsu_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_datain,
   input  logic [31:0] ram_dataout,
   output logic [1:0]  dbg_state
);

   localparam logic [31:0] LAST_BYTE = 32'(4 * DEPTH - 1);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] load_data;
   logic [31:0] merge_data;
   logic        access_err;

   lsu_lane_align u_align (
      .size_i   (size_q),
      .signed_i (signed_q),
      .off_i    (addr_q[1:0]),
      .rword_i  (ram_dataout),
      .wdata_i  (wdata_q),
      .load_o   (load_data),
      .merge_o  (merge_data)
   );

   // Out-of-range addresses are rejected outright rather than aliased onto the RAM.
   always_comb begin
      access_err = 1'b0;
      if (size_q == SIZE_RSV)                          access_err = 1'b1;
      if (size_q == SIZE_H && addr_q[0] != 1'b0)       access_err = 1'b1;
      if (size_q == SIZE_W && addr_q[1:0] != 2'b00)    access_err = 1'b1;
      if (addr_q > LAST_BYTE)                          access_err = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      signed_d   = signed_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      ram_we     = 1'b0;
      ram_addr   = 32'd0;
      ram_datain = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               size_d   = req_size;
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               state_d  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            ram_addr = {{(32-AW){1'b0}}, addr_q[AW+1:2]};
            if (access_err) begin
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else if (we_q) begin
               ram_we     = 1'b1;
               ram_datain = merge_data;
               err_d      = 1'b0;
               rdata_d    = 32'd0;
            end else begin
               err_d   = 1'b0;
               rdata_d = load_data;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         size_q   <= SIZE_B;
         signed_q <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Bench for lsu_ram_ctrl: a word RAM beside the DUT plus a byte-level reference
// memory that predicts every response and every RAM word.
module tb_lsu_ram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_datain;
   logic [31:0] ram_dataout;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   int we_pulses = 0;
   int cyc = 0;

   logic [31:0] ram [32];
   logic [31:0] mdl [32];

   always #5 clk = ~clk;

   lsu_ram_ctrl #(.DEPTH(32), .AW(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_signed  (req_signed),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_datain  (ram_datain),
      .ram_dataout (ram_dataout),
      .dbg_state   (dbg_state)
   );

   assign ram_dataout = ram[ram_addr[4:0]];

   always @(posedge clk) begin
      cyc++;
      if (ram_we) begin
         ram[ram_addr[4:0]] <= ram_datain;
         we_pulses++;
      end
   end

   // Reference: byte-addressed memory semantics, n bytes starting at addr.
   function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err);
      int n;
      int w;
      int b;
      longint unsigned v;
      n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      err = (size == 2'd3) || (addr % n != 0) || (addr >= 32'd128);
      rdata = 32'd0;
      if (err) return;
      w = int'(addr / 4);
      if (we) begin
         for (int j = 0; j < n; j++) begin
            b = int'(addr % 4) + j;
            mdl[w][8*b +: 8] = wdata[8*j +: 8];
         end
      end else begin
         v = 0;
         for (int j = 0; j < n; j++) begin
            b = int'(addr % 4) + j;
            v = v | (longint'(mdl[w][8*b +: 8]) << (8*j));
         end
         if (sgn && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
         rdata = v[31:0];
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int hold, input string tag, output int acc);
      logic [31:0] er;
      logic        ee;
      int          p0;
      int          budget;
      acc = -1;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      budget = 0;
      while (!req_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      chk({tag, "/req_ready"}, 64'(req_ready), 64'd1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      p0 = we_pulses;
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      chk({tag, "/access_flags"}, 64'({rsp_valid, req_ready}), 64'd0);
      model(we, size, sgn, addr, wdata, er, ee);
      @(posedge clk);
      #1;
      chk({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "/rsp"}, 64'({rsp_err, rsp_rdata}), 64'({ee, er}));
      chk({tag, "/we_pulses"}, 64'(we_pulses - p0), (we && !ee) ? 64'd1 : 64'd0);
      if (addr < 32'd128) chk({tag, "/ram_word"}, 64'(ram[addr[6:2]]), 64'(mdl[addr[6:2]]));
      rsp_ready = (hold == 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "/hold"}, 64'({rsp_valid, req_ready, rsp_err, rsp_rdata}),
             64'({1'b1, 1'b0, ee, er}));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "/done"}, 64'({rsp_valid, req_ready}), 64'b01);
   endtask

   initial begin
      int acc;
      int prev;
      int p0;
      logic [31:0] a;
      logic [1:0]  sz;
      logic        w;

      #2;
      chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_err, ram_we}), 64'b1000);
      chk("reset_ram_addr", 64'(ram_addr), 64'd0);
      chk("reset_ram_datain", 64'(ram_datain), 64'd0);
      chk("reset_rdata", 64'(rsp_rdata), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 32; i++) send(1'b1, 2'd2, 1'b0, 32'(4*i), $urandom, 0, "preload", acc);

      send(1'b1, 2'd2, 1'b0, 32'h50, 32'h000000A3, 0, "t1_init", acc);
      send(1'b0, 2'd0, 1'b1, 32'h50, 32'd0, 0, "t1_lb_signed", acc);
      send(1'b0, 2'd1, 1'b0, 32'h50, 32'd0, 0, "t1_lh_unsigned", acc);

      send(1'b1, 2'd0, 1'b0, 32'h51, 32'h0000005A, 0, "t2_sb", acc);
      send(1'b0, 2'd2, 1'b0, 32'h50, 32'd0, 0, "t2_lw_after_sb", acc);
      send(1'b1, 2'd1, 1'b0, 32'h52, 32'h0000BEEF, 0, "t2_sh", acc);
      send(1'b0, 2'd2, 1'b0, 32'h50, 32'd0, 0, "t2_lw_after_sh", acc);

      send(1'b0, 2'd1, 1'b0, 32'h51, 32'd0, 0, "t3_lh_misaligned", acc);
      send(1'b1, 2'd2, 1'b0, 32'h52, 32'hDEADBEEF, 0, "t3_sw_misaligned", acc);
      send(1'b1, 2'd3, 1'b0, 32'h50, 32'hCAFEF00D, 0, "t3_size_rsv", acc);

      send(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 0, "t4_lw_range", acc);
      send(1'b1, 2'd0, 1'b0, 32'h00000100, 32'h77, 0, "t4_sb_range_alias", acc);
      send(1'b0, 2'd2, 1'b0, 32'h7C, 32'd0, 0, "t4_lw_last", acc);

      send(1'b0, 2'd0, 1'b1, 32'h53, 32'd0, 5, "t5_hold", acc);
      prev = -1;
      for (int i = 0; i < 4; i++) begin
         send(1'($urandom), 2'd2, 1'b0, 32'(4*$urandom_range(0, 31)), $urandom, 0, "t5_burst", acc);
         if (prev >= 0) chk("t5_accept_spacing", 64'(acc - prev), 64'd3);
         prev = acc;
      end

      for (int i = 0; i < 80; i++) begin
         w  = 1'($urandom);
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         case ($urandom_range(0, 7))
            0:       a = $urandom;
            1:       a = 32'($urandom_range(128, 300));
            default: a = 32'($urandom_range(0, 127));
         endcase
         send(w, sz, 1'($urandom), a, $urandom, $urandom_range(0, 2), "random", acc);
      end

      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h00;
      req_wdata = 32'h11223344;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      p0 = we_pulses;
      chk("t6_we_in_access", 64'(ram_we), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_reset_flags", 64'({req_ready, rsp_valid, rsp_err, ram_we}), 64'b1000);
      chk("t6_reset_ram_addr", 64'(ram_addr), 64'd0);
      chk("t6_reset_ram_datain", 64'(ram_datain), 64'd0);
      chk("t6_reset_rdata", 64'(rsp_rdata), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("t6_no_rsp", 64'({rsp_valid, req_ready}), 64'b01);
      end
      chk("t6_no_write", 64'(we_pulses - p0), 64'd0);
      chk("t6_word0", 64'(ram[0]), 64'(mdl[0]));
      send(1'b0, 2'd2, 1'b0, 32'h00, 32'd0, 0, "t6_reload", acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
